// File: rtl/rv32i_muldiv_ctrl_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: funct3 op codes,
// the M-extension funct7 value and the FSM state type.
package rv32i_muldiv_ctrl_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rv32i_muldiv_iter.sv
// Combinational step of the iterative multiplier/divider: BITS_PER_CYCLE
// shift-add (multiply) or restoring trial-subtract (divide) steps on {hi,lo}.
module rv32i_muldiv_iter #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        i_is_div,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_opb,
    output logic [63:0] o_acc
);

    logic [63:0] w_acc;
    logic [32:0] w_sum;

    always_comb begin
        w_acc = i_acc;
        w_sum = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (i_is_div) begin
                // hi = partial remainder, lo = dividend bits shifting out / quotient bits in
                w_sum = w_acc[63:31];
                w_acc = {w_acc[62:0], 1'b0};
                if (w_sum >= {1'b0, i_opb}) begin
                    w_sum    = w_sum - {1'b0, i_opb};
                    w_acc[0] = 1'b1;
                end
                w_acc[63:32] = w_sum[31:0];
            end else begin
                w_sum = {1'b0, w_acc[63:32]} + (w_acc[0] ? {1'b0, i_opb} : 33'd0);
                w_acc = {w_sum, w_acc[31:1]};
            end
        end
    end

    assign o_acc = w_acc;

endmodule

// File: rtl/rv32i_muldiv_ctrl.sv
// RV32M multiply/divide sequencer beside the execute stage; stalls the ALU stage
// until the result is ready. Optional RV32M_FAST_MUL_EN: single-cycle multiplies.
module rv32i_muldiv_ctrl
    import rv32i_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_force_stall,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic        o_busy
);

    localparam int unsigned ITERS = 32 / BITS_PER_CYCLE;

    state_e      r_state, w_state_next;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opb;
    logic [2:0]  r_op;
    logic        r_neg;
    logic [31:0] r_result;

    logic        w_accept, w_sa, w_sb, w_neg, w_div0, w_ovf, w_bypass, w_last;
    logic [31:0] w_ma, w_mb, w_bypass_res, w_final, w_sel;
    logic [63:0] w_iter_acc, w_prod;

    assign w_accept = i_rst_n && (r_state == ST_IDLE) && i_start && i_ce && !i_stall && !i_flush;

    assign w_sa  = i_rs1[31] && (i_funct3 != F3_MULHU) && (i_funct3 != F3_DIVU) && (i_funct3 != F3_REMU);
    assign w_sb  = i_rs2[31] && (i_funct3 == F3_MUL || i_funct3 == F3_MULH ||
                                 i_funct3 == F3_DIV || i_funct3 == F3_REM);
    assign w_neg = (i_funct3[2] && i_funct3[1]) ? w_sa : (w_sa ^ w_sb);
    assign w_ma  = w_sa ? -i_rs1 : i_rs1;
    assign w_mb  = w_sb ? -i_rs2 : i_rs2;

    assign w_div0 = i_funct3[2] && (i_rs2 == '0);
    assign w_ovf  = i_funct3[2] && !i_funct3[0] && (i_rs1 == 32'h8000_0000) && (i_rs2 == '1);

`ifdef RV32M_FAST_MUL_EN
    logic signed [32:0] w_fa, w_fb;
    logic        [63:0] w_fp;
    assign w_fa = {(i_funct3 != F3_MULHU) && i_rs1[31], i_rs1};
    assign w_fb = {(i_funct3 == F3_MUL || i_funct3 == F3_MULH) && i_rs2[31], i_rs2};
    assign w_fp = 64'(w_fa * w_fb);
    assign w_bypass = w_div0 || w_ovf || !i_funct3[2];
    always_comb begin
        if (!i_funct3[2])
            w_bypass_res = (i_funct3 == F3_MUL) ? w_fp[31:0] : w_fp[63:32];
        else if (w_div0)
            w_bypass_res = i_funct3[1] ? i_rs1 : '1;
        else
            w_bypass_res = i_funct3[1] ? '0 : 32'h8000_0000;
    end
`else
    assign w_bypass = w_div0 || w_ovf;
    always_comb begin
        if (w_div0)
            w_bypass_res = i_funct3[1] ? i_rs1 : '1;
        else
            w_bypass_res = i_funct3[1] ? '0 : 32'h8000_0000;
    end
`endif

    rv32i_muldiv_iter #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_iter (
        .i_is_div(r_op[2]),
        .i_acc   (r_acc),
        .i_opb   (r_opb),
        .o_acc   (w_iter_acc)
    );

    assign w_last = (r_cnt == 6'(ITERS - 1));

    // Sign fix-up on the final iteration's output, registered straight into r_result
    always_comb begin
        w_prod  = r_neg ? -w_iter_acc : w_iter_acc;
        w_sel   = r_op[1] ? w_iter_acc[63:32] : w_iter_acc[31:0];
        w_final = '0;
        if (r_op[2])
            w_final = r_neg ? -w_sel : w_sel;
        else
            w_final = (r_op == F3_MUL) ? w_prod[31:0] : w_prod[63:32];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_bypass ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last)   w_state_next = ST_DONE;
            ST_DONE: if (!i_stall) w_state_next = ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
        if (i_flush) w_state_next = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op  <= i_funct3;
                r_neg <= w_neg;
                r_acc <= {32'd0, w_ma};
                r_opb <= w_mb;
                r_cnt <= '0;
                if (w_bypass) r_result <= w_bypass_res;
            end else if (r_state == ST_CALC && !i_flush) begin
                r_acc <= w_iter_acc;
                r_cnt <= r_cnt + 6'd1;
                if (w_last) r_result <= w_final;
            end
        end
    end

    assign o_force_stall = !i_flush && (w_accept || r_state == ST_CALC);
    assign o_done        = (r_state == ST_DONE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_result      = r_result;

endmodule

// File: tb/tb_rv32i_muldiv_ctrl.sv
// Self-checking bench for rv32i_muldiv_ctrl: directed vector table, random ops
// against an arithmetic reference model, and flush/stall/reset sequences.
module tb_rv32i_muldiv_ctrl;

    logic        i_clk, i_rst_n, i_ce, i_stall, i_flush, i_start;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1, i_rs2;
    logic        o_force_stall, o_done, o_busy;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    rv32i_muldiv_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_ce         (i_ce),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_start      (i_start),
        .i_funct3     (i_funct3),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .o_force_stall(o_force_stall),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RV32M_FAST_MUL_EN
        if (op < 3'd4) return 1;
`endif
        return 33;
    endfunction

    // Issue one op; optionally hold i_stall for 'hold' cycles once done is seen.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold);
        int  lat;
        bit  seen;
        bit  stall_ok;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_ce = 1'b1; i_funct3 = op; i_rs1 = a; i_rs2 = b;
        @(negedge i_clk);
        chk("force_stall_accept", 32'(o_force_stall), 32'd1);
        lat = 0; seen = 0; stall_ok = 1;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen = 1; lat = c;
            end else if (!o_force_stall) begin
                stall_ok = 0;
            end
        end
        chk("latency", lat, exp_lat(op, a, b));
        chk("force_stall_calc", 32'(stall_ok), 32'd1);
        if (!seen) begin
            i_flush = 1'b1; i_start = 1'b0;
            @(negedge i_clk);
            i_flush = 1'b0;
            return;
        end
        chk("result", o_result, exp);
        chk("force_stall_done", 32'(o_force_stall), 32'd0);
        if (hold > 0) begin
            i_stall = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge i_clk);
                chk("hold_done", 32'(o_done), 32'd1);
                chk("hold_result", o_result, exp);
            end
        end
        i_stall = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("idle_after_done", 32'(o_busy), 32'd0);
        chk("result_held", o_result, exp);
    endtask

    initial begin
        int          pulses;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[5]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vecs[6]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vecs[7]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[8]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        vecs[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[11] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};

        i_rst_n = 1'b0; i_ce = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_start = 1'b0; i_funct3 = '0; i_rs1 = '0; i_rs2 = '0;
        #3;
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_force_stall", 32'(o_force_stall), 32'd0);
        chk("reset_result", o_result, 32'd0);
        @(negedge i_clk); @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        // Stall held for 3 cycles in DONE with i_start still asserted
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, model(rop, ra, rb), 0);
        end

        // Flush in cycle 10 of a DIV
        @(posedge i_clk); #1;
        i_start = 1'b1; i_ce = 1'b1; i_funct3 = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge i_clk); #1;
        end
        i_flush = 1'b1; i_start = 1'b0;
        #1;
        chk("flush_force_stall", 32'(o_force_stall), 32'd0);
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        chk("flush_idle", 32'(o_busy), 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if (o_done) pulses++;
        end
        chk("flush_no_done", pulses, 0);

        // Async reset in the middle of CALC
        @(posedge i_clk); #1;
        i_start = 1'b1; i_funct3 = 3'd0; i_rs1 = 32'd12345; i_rs2 = 32'd678;
        for (int c = 0; c < 5; c++) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_done", 32'(o_done), 32'd0);
        chk("arst_force_stall", 32'(o_force_stall), 32'd0);
        chk("arst_result", o_result, 32'd0);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
